// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encodings
// and the per-stage destination tag carried through E, M and W.
package hazard_pkg;

  // Tag address field is sized for the widest register file supported (ADDR_W <= TAG_AW).
  localparam int unsigned TAG_AW = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] wa;
    logic              regwrite;
    logic              memtoreg;
    logic              pcwr;
    logic              multicyc;
  } stage_tag_t;

  function automatic fwd_sel_t fwd_pick(input logic m_hit, input logic w_hit);
    if (m_hit)      return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/hz_tag_stage.sv
// One pipeline-stage destination tag register; flush inserts a bubble and
// takes priority over the load enable.
module hz_tag_stage
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       flush,
  input  stage_tag_t d_i,
  output stage_tag_t q_o
);

  stage_tag_t tag_d, tag_q;

  always_comb begin
    tag_d = tag_q;
    if (flush)   tag_d = '0;
    else if (en) tag_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (reset) tag_q <= '0;
    else       tag_q <= tag_d;
  end

  assign q_o = tag_q;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Hazard controller for the F/D/E/M/W pipeline: tracks destination tags for
// E/M/W and produces forwarding selects, stalls, flushes and multi-cycle hold.
module hazard_ctrl_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NSRC   = 3,
  parameter int unsigned MC_LAT = 3,
  parameter int unsigned PC_REG = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*ADDR_W-1:0] RA_D,
  input  logic [NSRC-1:0]        RAValid_D,
  input  logic [ADDR_W-1:0]      WA_D,
  input  logic                   RegWrite_D,
  input  logic                   MemtoReg_D,
  input  logic                   PCWr_D,
  input  logic                   MultiCyc_D,
  input  logic                   BranchTakenE,
  output logic [2*NSRC-1:0]      ForwardE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   StallE,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   FlushM,
  output logic                   BusyE
);

  localparam int unsigned       CNT_W   = $clog2(MC_LAT);
  localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_REG);
  localparam logic [CNT_W-1:0]  MC_LOAD = CNT_W'(MC_LAT - 1);

  stage_tag_t              tag_dec, tag_e, tag_m, tag_w;
  logic [NSRC*ADDR_W-1:0]  ra_e_d, ra_e_q;
  logic [NSRC-1:0]         rav_e_d, rav_e_q;
  logic [CNT_W-1:0]        mc_cnt_d, mc_cnt_q;
  logic                    busy_e, ld_stall, ld_hit, pc_pend, br_taken;
  logic                    stall_e, flush_e;
  logic [2*NSRC-1:0]       fwd;
  logic [ADDR_W-1:0]       ra_i;
  logic                    m_hit, w_hit;
  logic                    unused_tags;

  hz_tag_stage u_stage_e (.clk(clk), .reset(reset), .en(~stall_e), .flush(flush_e), .d_i(tag_dec), .q_o(tag_e));
  hz_tag_stage u_stage_m (.clk(clk), .reset(reset), .en(1'b1),     .flush(stall_e), .d_i(tag_e),   .q_o(tag_m));
  hz_tag_stage u_stage_w (.clk(clk), .reset(reset), .en(1'b1),     .flush(1'b0),    .d_i(tag_m),   .q_o(tag_w));

  always_comb begin
    tag_dec                  = '0;
    tag_dec.valid            = 1'b1;
    tag_dec.wa[ADDR_W-1:0]   = WA_D;
    tag_dec.regwrite         = RegWrite_D;
    tag_dec.memtoreg         = MemtoReg_D;
    tag_dec.pcwr             = PCWr_D;
    tag_dec.multicyc         = MultiCyc_D;

    busy_e = (mc_cnt_q != '0);

    ld_hit = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (RAValid_D[i] && (RA_D[i*ADDR_W +: ADDR_W] == tag_e.wa[ADDR_W-1:0])) ld_hit = 1'b1;
    end
    ld_stall = tag_e.valid & tag_e.memtoreg & tag_e.regwrite & ld_hit & ~busy_e;
    pc_pend  = (PCWr_D & RegWrite_D) | tag_e.pcwr | tag_m.pcwr;
    br_taken = BranchTakenE & ~busy_e;
    stall_e  = busy_e;
    flush_e  = (ld_stall | br_taken) & ~busy_e;

    fwd   = '0;
    ra_i  = '0;
    m_hit = 1'b0;
    w_hit = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      ra_i  = ra_e_q[i*ADDR_W +: ADDR_W];
      m_hit = rav_e_q[i] & tag_m.valid & tag_m.regwrite & (tag_m.wa[ADDR_W-1:0] == ra_i) & (ra_i != PC_A);
      w_hit = rav_e_q[i] & tag_w.valid & tag_w.regwrite & (tag_w.wa[ADDR_W-1:0] == ra_i) & (ra_i != PC_A);
      fwd[2*i +: 2] = fwd_pick(m_hit, w_hit);
    end
  end

  // E-side source addresses follow the same hold/bubble rules as the E tag.
  always_comb begin
    ra_e_d   = ra_e_q;
    rav_e_d  = rav_e_q;
    mc_cnt_d = mc_cnt_q;
    if (flush_e) begin
      ra_e_d  = '0;
      rav_e_d = '0;
    end else if (!stall_e) begin
      ra_e_d  = RA_D;
      rav_e_d = RAValid_D;
    end
    if (busy_e)                          mc_cnt_d = mc_cnt_q - CNT_W'(1);
    else if (!flush_e && MultiCyc_D)     mc_cnt_d = MC_LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ra_e_q   <= '0;
      rav_e_q  <= '0;
      mc_cnt_q <= '0;
    end else begin
      ra_e_q   <= ra_e_d;
      rav_e_q  <= rav_e_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  always_comb begin
    ForwardE = '0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    BusyE    = 1'b0;
    if (!reset) begin
      ForwardE = fwd;
      StallE   = stall_e;
      StallD   = ld_stall | busy_e;
      StallF   = ld_stall | pc_pend | busy_e;
      FlushD   = (pc_pend | br_taken) & ~busy_e;
      FlushE   = flush_e;
      FlushM   = busy_e;
      BusyE    = busy_e;
    end
  end

  assign unused_tags = ^{tag_e, tag_m, tag_w};

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Cycle-by-cycle bench for hazard_ctrl_pipe: each step drives one decode
// instruction and queues the hand-derived outputs expected for that cycle.
module tb_hazard_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] RA_D;
  logic [2:0]  RAValid_D;
  logic [3:0]  WA_D;
  logic        RegWrite_D, MemtoReg_D, PCWr_D, MultiCyc_D, BranchTakenE;
  logic [5:0]  ForwardE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned step_no  = 0;
  logic [12:0] exp_q[$];

  typedef struct packed {
    logic [11:0] ra;
    logic [2:0]  rav;
    logic [3:0]  wa;
    logic        rw, mtr, pcw, mc;
  } instr_t;

  // Flag vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_LD   = 7'b1100100;
  localparam logic [6:0] F_LDBR = 7'b1101100;
  localparam logic [6:0] F_BR   = 7'b0001100;
  localparam logic [6:0] F_PC   = 7'b1001000;
  localparam logic [6:0] F_BUSY = 7'b1110011;

  hazard_ctrl_pipe #(.ADDR_W(4), .NSRC(3), .MC_LAT(3), .PC_REG(15)) dut (
    .clk(clk), .reset(reset), .RA_D(RA_D), .RAValid_D(RAValid_D), .WA_D(WA_D),
    .RegWrite_D(RegWrite_D), .MemtoReg_D(MemtoReg_D), .PCWr_D(PCWr_D),
    .MultiCyc_D(MultiCyc_D), .BranchTakenE(BranchTakenE), .ForwardE(ForwardE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
    .FlushE(FlushE), .FlushM(FlushM), .BusyE(BusyE)
  );

  always #5 clk = ~clk;

  function automatic instr_t mk(input int r0, input int r1, input int r2, input logic [2:0] rav,
                                input int wa, input logic rw, input logic mtr,
                                input logic pcw, input logic mc);
    instr_t t;
    t.ra  = {4'(r2), 4'(r1), 4'(r0)};
    t.rav = rav;
    t.wa  = 4'(wa);
    t.rw  = rw;
    t.mtr = mtr;
    t.pcw = pcw;
    t.mc  = mc;
    return t;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input instr_t ins, input logic br,
                      input logic [5:0] efwd, input logic [6:0] eflg);
    logic [12:0] e;
    step_no++;
    reset        = rst;
    RA_D         = ins.ra;
    RAValid_D    = ins.rav;
    WA_D         = ins.wa;
    RegWrite_D   = ins.rw;
    MemtoReg_D   = ins.mtr;
    PCWr_D       = ins.pcw;
    MultiCyc_D   = ins.mc;
    BranchTakenE = br;
    exp_q.push_back({efwd, eflg});
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq($sformatf("fwd@%0d", step_no), 32'(ForwardE), 32'(e[12:7]));
    check_eq($sformatf("flags@%0d", step_no),
             32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, BusyE}), 32'(e[6:0]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t nop, add1, sub, a1, orr, rd1, w15, rd15, ldr4, add5, ldrpc, mul6, add7, mula, mulb, ldr3, rd3, rd6;
    nop   = mk(0, 0, 0, 3'b000,  0, 0, 0, 0, 0);
    add1  = mk(2, 3, 0, 3'b011,  1, 1, 0, 0, 0);
    sub   = mk(1, 3, 0, 3'b011,  2, 1, 0, 0, 0);
    a1    = mk(0, 0, 0, 3'b000,  1, 1, 0, 0, 0);
    orr   = mk(1, 1, 5, 3'b111,  8, 1, 0, 0, 0);
    rd1   = mk(1, 0, 0, 3'b001,  9, 1, 0, 0, 0);
    w15   = mk(0, 0, 0, 3'b000, 15, 1, 0, 0, 0);
    rd15  = mk(15, 0, 0, 3'b001, 9, 1, 0, 0, 0);
    ldr4  = mk(6, 0, 0, 3'b001,  4, 1, 1, 0, 0);
    add5  = mk(4, 4, 0, 3'b011,  5, 1, 0, 0, 0);
    ldrpc = mk(2, 0, 0, 3'b001, 15, 1, 1, 1, 0);
    mul6  = mk(1, 2, 0, 3'b011,  6, 1, 0, 0, 1);
    add7  = mk(6, 0, 0, 3'b001,  7, 1, 0, 0, 0);
    mula  = mk(0, 0, 0, 3'b000, 10, 1, 0, 0, 1);
    mulb  = mk(0, 0, 0, 3'b000, 11, 1, 0, 0, 1);
    ldr3  = mk(0, 0, 0, 3'b000,  3, 1, 1, 0, 0);
    rd3   = mk(3, 0, 0, 3'b001,  9, 1, 0, 0, 0);
    rd6   = mk(6, 0, 0, 3'b001,  9, 1, 0, 0, 0);

    reset = 1'b1;
    {RA_D, RAValid_D, WA_D, RegWrite_D, MemtoReg_D, PCWr_D, MultiCyc_D, BranchTakenE} = '0;
    @(posedge clk);
    #1;

    // Reset: outputs forced low even with a PC-writing decode and a taken branch.
    step(1, ldrpc, 1, 6'b000000, F_NONE);
    step(1, ldrpc, 1, 6'b000000, F_NONE);

    // Forward from M.
    step(0, add1, 0, 6'b000000, F_NONE);
    step(0, sub,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000010, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);

    // M beats W; then W alone.
    step(0, a1,   0, 6'b000000, F_NONE);
    step(0, a1,   0, 6'b000000, F_NONE);
    step(0, orr,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b001010, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, a1,   0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, rd1,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000001, F_NONE);

    // Writes to PC_REG never forward, from M or W.
    step(0, w15,  0, 6'b000000, F_NONE);
    step(0, rd15, 0, 6'b000000, F_NONE);
    step(0, rd15, 0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);

    // Load-use: one stall cycle then forward from W on both ports.
    step(0, ldr4, 0, 6'b000000, F_NONE);
    step(0, add5, 0, 6'b000000, F_LD);
    step(0, add5, 0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000101, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);

    // PC write pending while the op is in D, E and M.
    step(0, ldrpc, 0, 6'b000000, F_PC);
    step(0, nop,   0, 6'b000000, F_PC);
    step(0, nop,   0, 6'b000000, F_PC);
    step(0, nop,   0, 6'b000000, F_NONE);
    step(0, nop,   0, 6'b000000, F_NONE);

    // Multi-cycle op, dependent reader, taken branch ignored while busy.
    step(0, mul6, 0, 6'b000000, F_NONE);
    step(0, add7, 0, 6'b000000, F_BUSY);
    step(0, add7, 1, 6'b000000, F_BUSY);
    step(0, add7, 0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000010, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);

    // Back-to-back multi-cycle ops reload with no idle cycle.
    step(0, mula, 0, 6'b000000, F_NONE);
    step(0, mulb, 0, 6'b000000, F_BUSY);
    step(0, mulb, 0, 6'b000000, F_BUSY);
    step(0, mulb, 0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_BUSY);
    step(0, nop,  0, 6'b000000, F_BUSY);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);

    // Load-use coinciding with a taken branch; then a lone taken branch.
    step(0, ldr3, 0, 6'b000000, F_NONE);
    step(0, rd3,  1, 6'b000000, F_LDBR);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, nop,  1, 6'b000000, F_BR);

    // Reset in the middle of a multi-cycle op.
    step(0, mul6, 0, 6'b000000, F_NONE);
    step(0, rd6,  0, 6'b000000, F_BUSY);
    step(1, rd6,  1, 6'b000000, F_NONE);
    step(1, rd6,  0, 6'b000000, F_NONE);
    step(0, rd6,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);
    step(0, nop,  0, 6'b000000, F_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
